// File: rtl/cacheline_adaptor.sv
// Moves one cache line between the 256-bit cache datapath and a 64-bit burst memory port.
// Fills collect four beats into a line, and writebacks split a line into four beats.
module cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_burst  = 64,
    localparam int s_line  = 8 * 2**s_offset,
    localparam int beats   = s_line / s_burst,
    localparam int cnt_w   = $clog2(beats)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

    state_t             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [s_line-1:0]  buf_q, buf_d;
    logic [s_burst-1:0] burst_q, burst_d;
    logic [31:0]        addr_q, addr_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        resp_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Read has priority when both requests arrive together.
                if (read_i) begin
                    state_d = READ;
                    read_d  = 1'b1;
                    cnt_d   = '0;
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                end else if (write_i) begin
                    state_d = WRITE;
                    write_d = 1'b1;
                    cnt_d   = '0;
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                    buf_d   = line_i;
                    burst_d = line_i[s_burst-1:0];
                end
            end
            READ: begin
                read_d = 1'b1;
                if (resp_i) begin
                    buf_d[s_burst*int'(cnt_q) +: s_burst] = burst_i;
                    cnt_d = cnt_q + cnt_w'(1);
                    if (cnt_q == last_beat) begin
                        state_d = DONE;
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                write_d = 1'b1;
                if (resp_i) begin
                    cnt_d = cnt_q + cnt_w'(1);
                    // Preload the next beat so burst_o is ready when the memory strobes again.
                    burst_d = buf_q[s_burst*int'(cnt_d) +: s_burst];
                    if (cnt_q == last_beat) begin
                        state_d = DONE;
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign line_o    = buf_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

endmodule
